// File: rtl/serial_pattern_tx.sv
// rtl/serial_pattern_tx.sv - serial bit-pattern transmitter with programmable repeats and idle gaps
// Captures a parallel pattern on start and shifts it out one bit per clock; all outputs registered.
module serial_pattern_tx #(
  parameter int WIDTH    = 8,
  parameter int REPEAT_W = 4,
  parameter int GAP      = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [WIDTH-1:0]    pattern,
  input  logic [REPEAT_W-1:0] repeat_cnt,
  input  logic                msb_first,
  output logic                out,
  output logic                valid,
  output logic                busy,
  output logic                done
);

  localparam int IW = $clog2(WIDTH);
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP, S_DONE} state_t;

  state_t              state;
  logic [WIDTH-1:0]    pat_q;
  logic [WIDTH-1:0]    ordered;
  logic [IW-1:0]       bit_idx;
  logic [REPEAT_W-1:0] rep;
  logic [GW-1:0]       gap_cnt;

  // Bit order is resolved at capture so the shifter always sends pat_q[0] first.
  always_comb begin
    ordered = '0;
    for (int i = 0; i < WIDTH; i++) begin
      ordered[i] = msb_first ? pattern[WIDTH-1-i] : pattern[i];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      pat_q   <= '0;
      bit_idx <= '0;
      rep     <= '0;
      gap_cnt <= '0;
      out     <= 1'b0;
      valid   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          out   <= 1'b0;
          valid <= 1'b0;
          busy  <= 1'b0;
          if (start) begin
            pat_q   <= ordered;
            bit_idx <= '0;
            if (repeat_cnt == '0) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              rep   <= repeat_cnt;
              state <= S_SHIFT;
              out   <= ordered[0];
              valid <= 1'b1;
              busy  <= 1'b1;
            end
          end
        end

        S_SHIFT: begin
          if (bit_idx == IW'(WIDTH - 1)) begin
            rep     <= rep - 1'b1;
            bit_idx <= '0;
            if (rep != REPEAT_W'(1)) begin
              if (GAP > 0) begin
                state   <= S_GAP;
                gap_cnt <= '0;
                out     <= 1'b0;
                valid   <= 1'b0;
              end else begin
                out <= pat_q[0];
              end
            end else begin
              state <= S_DONE;
              out   <= 1'b0;
              valid <= 1'b0;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end else begin
            bit_idx <= bit_idx + 1'b1;
            out     <= pat_q[bit_idx + 1'b1];
          end
        end

        S_GAP: begin
          // busy stays high through the gap; only valid/out drop.
          if (gap_cnt == GW'(GAP - 1)) begin
            state   <= S_SHIFT;
            gap_cnt <= '0;
            out     <= pat_q[0];
            valid   <= 1'b1;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end

        S_DONE: begin
          state <= S_IDLE;
          out   <= 1'b0;
          valid <= 1'b0;
          busy  <= 1'b0;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_pattern_tx.sv
// tb/tb_serial_pattern_tx.sv - scoreboard bench for serial_pattern_tx
// Driver predicts cycle-stamped bits, busy window and done cycle; a negedge monitor checks them.
module tb_serial_pattern_tx;
  localparam int W   = 8;
  localparam int RW  = 4;
  localparam int GP  = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [W-1:0]  pattern = '0;
  logic [RW-1:0] repeat_cnt = '0;
  logic          msb_first = 1'b0;
  logic          out, valid, busy, done;

  serial_pattern_tx #(.WIDTH(W), .REPEAT_W(RW), .GAP(GP)) dut (
    .clk(clk), .reset(reset), .start(start), .pattern(pattern),
    .repeat_cnt(repeat_cnt), .msb_first(msb_first),
    .out(out), .valid(valid), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct { int c; bit b; } ent_t;
  ent_t bitq[$];
  int   cyc = 0;
  int   free_at = 0;
  int   busy_lo = 0, busy_hi = -1;
  int   done_cyc = -1;
  int   tests = 0, fails = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Reference: R repeats of W bits, each burst GP cycles after the previous one ends.
  task automatic accept(int t, logic [W-1:0] p, int r, bit m);
    if (r == 0) begin
      done_cyc = t + 1;
    end else begin
      for (int k = 0; k < r; k++)
        for (int i = 0; i < W; i++) begin
          ent_t e;
          e.c = t + 1 + k * (W + GP) + i;
          e.b = m ? p[W-1-i] : p[i];
          bitq.push_back(e);
        end
      busy_lo  = t + 1;
      busy_hi  = t + r * W + (r - 1) * GP;
      done_cyc = busy_hi + 1;
    end
    free_at = done_cyc + 1;
  endtask

  task automatic flush(int tr);
    while (bitq.size() > 0 && bitq[$].c > tr) void'(bitq.pop_back());
    if (busy_hi > tr) busy_hi = tr;
    if (done_cyc > tr) done_cyc = -1;
    free_at = tr + 1;
  endtask

  task automatic drive(bit s, logic [W-1:0] p, int r, bit m, bit rst);
    @(posedge clk);
    #1;
    start = s; pattern = p; repeat_cnt = RW'(r); msb_first = m; reset = rst;
    if (rst) flush(cyc);
    else if (s && cyc >= free_at) accept(cyc, p, r, m);
  endtask

  task automatic idle_until_free();
    for (int n = 0; n < 400 && cyc < free_at; n++) drive(0, W'($urandom), 1, 0, 0);
  endtask

  always @(negedge clk) begin
    if (cyc >= 1) begin
      ent_t e;
      if (valid === 1'b1) begin
        if (bitq.size() == 0) begin
          chk("unexpected_valid", 1, 0);
        end else begin
          e = bitq.pop_front();
          chk("bit_cycle", cyc, e.c);
          chk("bit_value", out, e.b);
        end
      end else begin
        chk("idle_out", out, 0);
        if (bitq.size() > 0 && bitq[0].c <= cyc) begin
          chk("bit_missing", 0, 1);
          void'(bitq.pop_front());
        end
      end
      chk("busy", busy, (cyc >= busy_lo && cyc <= busy_hi) ? 1 : 0);
      if (done === 1'b1) begin
        chk("done_cycle", cyc, done_cyc);
        done_cyc = -1;
      end else if (done_cyc != -1 && cyc >= done_cyc) begin
        chk("done_missing", 0, 1);
        done_cyc = -1;
      end
    end
  end

  initial begin
    for (int i = 0; i < 3; i++) drive(0, '0, 0, 0, 1);
    drive(0, '0, 0, 0, 0);
    // Directed cases: msb/lsb order, repeats with gaps, zero repeats.
    drive(1, 8'hB4, 1, 1, 0); idle_until_free();
    drive(1, 8'hB4, 1, 0, 0); idle_until_free();
    drive(1, 8'hB4, 3, 1, 0); idle_until_free();
    drive(1, 8'hB4, 0, 1, 0); idle_until_free();
    // Re-pulse during a burst must be ignored.
    drive(1, 8'hB4, 1, 1, 0);
    for (int i = 0; i < 3; i++) drive(0, 8'h00, 1, 1, 0);
    drive(1, 8'hFF, 1, 1, 0);
    idle_until_free();
    // Reset mid-burst, then a fresh start.
    drive(1, 8'hB4, 1, 1, 0);
    for (int i = 0; i < 4; i++) drive(0, 8'h00, 1, 1, 0);
    drive(0, 8'h00, 1, 1, 1);
    for (int i = 0; i < 2; i++) drive(0, 8'h00, 1, 1, 0);
    drive(1, 8'h81, 1, 1, 0);
    idle_until_free();
    // Maximum repeat count.
    drive(1, 8'h5A, 15, 0, 0); idle_until_free();
    // Start held high retriggers right after each done.
    for (int i = 0; i < 60; i++) drive(1, W'($urandom), $urandom_range(0, 3), 1'($urandom), 0);
    // Random traffic with occasional resets.
    for (int i = 0; i < 1500; i++)
      drive($urandom_range(0, 3) == 0, W'($urandom), $urandom_range(0, 4), 1'($urandom),
            $urandom_range(0, 199) == 0);
    idle_until_free();
    chk("drain_timeout", (cyc >= free_at) ? 1 : 0, 1);
    for (int i = 0; i < 3; i++) drive(0, '0, 0, 0, 0);
    @(negedge clk);
    #1;
    chk("queue_empty", bitq.size(), 0);
    chk("done_pending", done_cyc, -1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
